// File: rtl/apbtoburst_fifo_bridge.sv
// rtl/apbtoburst_fifo_bridge.sv - APB slave with TX/RX FIFOs feeding a burst-master FSM
// Optional interrupt output enabled by defining APBTOBURST_IRQ_EN.
module apbtoburst_fifo_bridge #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int LEN_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] paddr,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              plsverr,
  output logic              apb_rd_done,
  output logic              idle,
  output logic              burst_valid,
  input  logic              burst_ready,
  output logic [DATA_W-1:0] data_burst_out,
  output logic              burst_last,
  output logic [LEN_W-1:0]  db_length,
  input  logic              db_valid,
  output logic              db_ready,
  input  logic [DATA_W-1:0] data_burst_in,
  input  logic              last
`ifdef APBTOBURST_IRQ_EN
  ,
  output logic              irq
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int EXT_W = (DATA_W > 32) ? DATA_W : 32;
  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_OUT, S_IN} state_t;

  state_t            state;
  logic [LEN_W-1:0]  beat_cnt;
  logic              seq_err;
  logic              irq_pend;

  logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  tx_wp, tx_rp, rx_wp, rx_rp;
  logic [LEN_W-1:0]  tx_count, rx_count;

  // Register fields are picked out of a write word at least 32 bits wide.
  logic [EXT_W-1:0] wd;
  logic             unused_bits;
  assign wd          = EXT_W'(pwdata);
  assign unused_bits = ^wd;

  logic access, is_data, is_ctrl, is_stat, busy;
  assign access  = psel & penable;
  assign is_data = (paddr == ADDR_W'(0));
  assign is_ctrl = (paddr == ADDR_W'(4));
  assign is_stat = (paddr == ADDR_W'(8));
  assign busy    = ~idle;

  logic [LEN_W-1:0] ctrl_len;
  logic             ctrl_dir, ctrl_bad;
  assign ctrl_len = wd[LEN_W-1:0];
  assign ctrl_dir = wd[31];
  assign ctrl_bad = busy || (ctrl_len == '0) || (ctrl_len > DEPTH_L) ||
                    (!ctrl_dir && (ctrl_len > tx_count)) ||
                    ( ctrl_dir && (ctrl_len > (DEPTH_L - rx_count)));

  logic err, ctrl_go, stat_wr, tx_push, tx_pop, rx_push, rx_pop;
  assign err = access && (
                 (is_data &&  pwrite && (tx_count == DEPTH_L)) ||
                 (is_data && !pwrite && (rx_count == '0)) ||
                 (is_ctrl && (!pwrite || ctrl_bad)) ||
                 !(is_data || is_ctrl || is_stat));
  assign ctrl_go = access && is_ctrl && pwrite && !err;
  assign stat_wr = access && is_stat && pwrite;
  assign tx_push = access && is_data &&  pwrite && !err;
  assign rx_pop  = access && is_data && !pwrite && !err;
  assign tx_pop  = burst_valid && burst_ready;
  assign rx_push = db_valid && db_ready;

  assign db_ready       = (state == S_IN) && (rx_count != DEPTH_L);
  assign data_burst_out = tx_mem[tx_rp];

  logic in_final, seq_evt, done_evt;
  assign in_final = (beat_cnt == db_length - LEN_W'(1));
  assign seq_evt  = (state == S_IN) && rx_push && (last != in_final);
  assign done_evt = ((state == S_OUT) && tx_pop && burst_last) ||
                    ((state == S_IN) && rx_push && in_final);

  logic [EXT_W-1:0] status;
  // Assemble the STATUS word from live counts and sticky flags.
  always_comb begin
    status              = '0;
    status[LEN_W-1:0]   = tx_count;
    status[8 +: LEN_W]  = rx_count;
    status[24]          = busy;
    status[25]          = seq_err;
    status[26]          = irq_pend;
  end

  // Zero-wait-state read data and error, only driven in the access phase.
  always_comb begin
    prdata  = '0;
    plsverr = err;
    if (access && !pwrite && !err) begin
      if (is_data)      prdata = rx_mem[rx_rp];
      else if (is_stat) prdata = status[DATA_W-1:0];
    end
  end

  // FIFO storage needs no reset; pointers define what is valid.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= pwdata;
    if (rx_push) rx_mem[rx_wp] <= data_burst_in;
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wp <= '0; tx_rp <= '0; tx_count <= '0;
      rx_wp <= '0; rx_rp <= '0; rx_count <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + PTR_W'(1);
      if (tx_pop)  tx_rp <= tx_rp + PTR_W'(1);
      if (rx_push) rx_wp <= rx_wp + PTR_W'(1);
      if (rx_pop)  rx_rp <= rx_rp + PTR_W'(1);
      tx_count <= tx_count + LEN_W'(tx_push) - LEN_W'(tx_pop);
      rx_count <= rx_count + LEN_W'(rx_push) - LEN_W'(rx_pop);
    end
  end

  // Burst FSM with registered handshake/status outputs and sticky sequence error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      beat_cnt    <= '0;
      db_length   <= '0;
      idle        <= 1'b1;
      burst_valid <= 1'b0;
      burst_last  <= 1'b0;
      apb_rd_done <= 1'b0;
      seq_err     <= 1'b0;
    end else begin
      apb_rd_done <= 1'b0;
      seq_err     <= seq_evt || (seq_err && !(stat_wr && wd[25]));
      case (state)
        S_IDLE: if (ctrl_go) begin
          state       <= ctrl_dir ? S_IN : S_OUT;
          db_length   <= ctrl_len;
          beat_cnt    <= '0;
          idle        <= 1'b0;
          burst_valid <= !ctrl_dir;
          burst_last  <= !ctrl_dir && (ctrl_len == LEN_W'(1));
        end
        S_OUT: if (tx_pop) begin
          if (burst_last) begin
            state       <= S_IDLE;
            idle        <= 1'b1;
            burst_valid <= 1'b0;
            burst_last  <= 1'b0;
          end else begin
            beat_cnt   <= beat_cnt + LEN_W'(1);
            burst_last <= (beat_cnt + LEN_W'(2)) == db_length;
          end
        end
        S_IN: if (rx_push) begin
          if (in_final) begin
            state       <= S_IDLE;
            idle        <= 1'b1;
            apb_rd_done <= 1'b1;
          end else begin
            beat_cnt <= beat_cnt + LEN_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef APBTOBURST_IRQ_EN
  // Pending interrupt: completion or sequence error sets it, set wins over clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_pend <= 1'b0;
    else        irq_pend <= seq_evt || done_evt || (irq_pend && !(stat_wr && wd[26]));
  end
  assign irq = irq_pend;
`else
  logic unused_done;
  assign unused_done = done_evt;
  assign irq_pend    = 1'b0;
`endif

endmodule

// File: tb/tb_apbtoburst_fifo_bridge.sv
// tb/tb_apbtoburst_fifo_bridge.sv - randomized self-checking bench with queue-based reference model
module tb_apbtoburst_fifo_bridge;

  localparam int DEPTH = 16;

  logic        clk = 0;
  logic        rst_n = 0;
  logic [7:0]  paddr = 0;
  logic        psel = 0, penable = 0, pwrite = 0;
  logic [31:0] pwdata = 0;
  logic [31:0] prdata;
  logic        plsverr, apb_rd_done, idle, burst_valid, burst_last, db_ready;
  logic        burst_ready = 0, db_valid = 0, last = 0;
  logic [31:0] data_burst_out;
  logic [31:0] data_burst_in = 0;
  logic [4:0]  db_length;
`ifdef APBTOBURST_IRQ_EN
  logic        irq;
`endif

  apbtoburst_fifo_bridge dut (
    .clk(clk), .rst_n(rst_n), .paddr(paddr), .psel(psel), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata), .plsverr(plsverr),
    .apb_rd_done(apb_rd_done), .idle(idle), .burst_valid(burst_valid),
    .burst_ready(burst_ready), .data_burst_out(data_burst_out),
    .burst_last(burst_last), .db_length(db_length), .db_valid(db_valid),
    .db_ready(db_ready), .data_burst_in(data_burst_in), .last(last)
`ifdef APBTOBURST_IRQ_EN
    , .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] tx_q[$];
  logic [31:0] rx_q[$];
  bit seq_m = 0;
  bit irq_m = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_status(input bit busy);
    logic [31:0] s;
    s = 0;
    s[4:0]  = 5'(tx_q.size());
    s[12:8] = 5'(rx_q.size());
    s[24]   = busy;
    s[25]   = seq_m;
`ifdef APBTOBURST_IRQ_EN
    s[26]   = irq_m;
`endif
    return s;
  endfunction

  // One APB transfer; entered and left one time unit after a rising edge.
  task automatic apb(input logic wr, input logic [7:0] a, input logic [31:0] w,
                     output logic e, output logic [31:0] rd);
    psel = 1; penable = 0; pwrite = wr; paddr = a; pwdata = w;
    @(posedge clk); #1;
    penable = 1;
    #1;
    e = plsverr; rd = prdata;
    @(posedge clk); #1;
    psel = 0; penable = 0; pwrite = 0;
  endtask

  task automatic acc(input string tag, input logic wr, input logic [7:0] a, input logic [31:0] w,
                     input bit exp_err, input logic [31:0] exp_rd);
    logic e;
    logic [31:0] rd;
    apb(wr, a, w, e, rd);
    chk({tag, "_err"}, e, exp_err);
    if (exp_err || !wr) chk({tag, "_rdata"}, rd, exp_rd);
  endtask

  task automatic data_wr(input logic [31:0] v);
    bit e;
    e = (tx_q.size() == DEPTH);
    acc("data_wr", 1, 8'h00, v, e, 0);
    if (!e) tx_q.push_back(v);
  endtask

  task automatic data_rd();
    bit e;
    logic [31:0] x;
    e = (rx_q.size() == 0);
    x = e ? 32'h0 : rx_q[0];
    acc("data_rd", 0, 8'h00, 0, e, x);
    if (!e) void'(rx_q.pop_front());
  endtask

  task automatic stat_rd(input bit busy);
    acc("status", 0, 8'h08, 0, 0, exp_status(busy));
  endtask

  task automatic stat_wr(input logic [31:0] v);
    acc("status_wr", 1, 8'h08, v, 0, 0);
    if (v[25]) seq_m = 0;
    if (v[26]) irq_m = 0;
  endtask

  task automatic run_out(input int len, input int mode);
    int beats = 0;
    int cyc = 0;
    bit r;
    while (beats < len && cyc < 300) begin
      chk("out_valid", burst_valid, 1);
      chk("out_data", data_burst_out, tx_q[0]);
      chk("out_last", burst_last, beats == len - 1);
      r = (mode == 0) ? 1'b1 : (mode == 1) ? bit'(cyc % 2) : bit'($urandom % 2);
      burst_ready = r;
      @(posedge clk); #1;
      if (r) begin
        void'(tx_q.pop_front());
        beats++;
      end
      cyc++;
    end
    burst_ready = 0;
    chk("out_beats", beats, len);
    if (mode == 0) chk("out_rate", cyc, len);
    irq_m = 1;
    chk("out_end_idle", idle, 1);
    chk("out_end_valid", burst_valid, 0);
    chk("out_end_last", burst_last, 0);
  endtask

  task automatic run_in(input int len, input int mode, input int lastpos);
    int beats = 0;
    int cyc = 0;
    logic v;
    while (beats < len && cyc < 300) begin
      chk("in_ready", db_ready, 1);
      chk("in_done_early", apb_rd_done, 0);
      v = (mode == 0) ? 1'b1 : 1'(($urandom % 2));
      db_valid = v;
      data_burst_in = $urandom;
      last = (beats + 1 == lastpos);
      @(posedge clk); #1;
      if (v) begin
        rx_q.push_back(data_burst_in);
        beats++;
        if (last != (beats == len)) seq_m = 1;
      end
      cyc++;
    end
    db_valid = 0; last = 0;
    chk("in_beats", beats, len);
    irq_m = 1;
    chk("in_done", apb_rd_done, 1);
    chk("in_end_idle", idle, 1);
    chk("in_end_ready", db_ready, 0);
    @(posedge clk); #1;
    chk("in_done_pulse", apb_rd_done, 0);
  endtask

  task automatic ctrl(input int len, input bit dir, input bit busy, input bit run,
                      input int mode, input int lastpos);
    bit e;
    logic [31:0] w;
    e = busy || len == 0 || len > DEPTH ||
        (!dir && len > tx_q.size()) || (dir && len > DEPTH - rx_q.size());
    w = {dir, 31'b0} | ($urandom & 32'h00FF_FF00) | 32'(len);
    acc("ctrl", 1, 8'h04, w, e, 0);
    if (!e) begin
      chk("db_length", db_length, len);
      if (run) begin
        if (dir) run_in(len, mode, lastpos);
        else     run_out(len, mode);
      end
    end
  endtask

  initial begin
    int len;
    logic [7:0] a;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_idle_lo", idle, 1);
    rst_n = 1;
    @(posedge clk); #1;

    // Reset values
    chk("rst_prdata", prdata, 0);
    chk("rst_plsverr", plsverr, 0);
    chk("rst_rd_done", apb_rd_done, 0);
    chk("rst_idle", idle, 1);
    chk("rst_bvalid", burst_valid, 0);
    chk("rst_blast", burst_last, 0);
    chk("rst_dbready", db_ready, 0);
    chk("rst_dblen", db_length, 0);
`ifdef APBTOBURST_IRQ_EN
    chk("rst_irq", irq, 0);
`endif
    stat_rd(0);

    // OUT of 3 at full rate
    data_wr(32'hA1); data_wr(32'hA2); data_wr(32'hA3);
    ctrl(3, 0, 0, 1, 0, 0);

    // IN of 4 with correct last, drained over APB, then empty read
    ctrl(4, 1, 0, 1, 0, 4);
    repeat (4) data_rd();
    data_rd();
    stat_rd(0);

    // TX full, bad lengths, then a randomly throttled 16-beat OUT
    for (int i = 0; i < 17; i++) data_wr($urandom);
    stat_rd(0);
    chk("tx_full_count", tx_q.size(), DEPTH);
    ctrl(0, 0, 0, 1, 0, 0);
    ctrl(17, 0, 0, 1, 0, 0);
    ctrl(16, 0, 0, 1, 2, 0);

    // OUT of 4 with burst_ready toggled
    for (int i = 0; i < 4; i++) data_wr(32'hB0 + 32'(i));
    ctrl(4, 0, 0, 1, 1, 0);

    // IN of 3 with early last: sequence error and interrupt, then clear
    ctrl(3, 1, 0, 1, 0, 2);
    stat_rd(0);
`ifdef APBTOBURST_IRQ_EN
    chk("irq_set", irq, 1);
`endif
    stat_wr(32'h0600_0000);
    stat_rd(0);
`ifdef APBTOBURST_IRQ_EN
    chk("irq_clr", irq, 0);
`endif
    repeat (3) data_rd();

    // DATA access and CTRL rejection while an OUT burst is stalled
    data_wr(32'hC1); data_wr(32'hC2);
    ctrl(2, 0, 0, 0, 0, 0);
    data_wr(32'hC3);
    stat_rd(1);
    ctrl(1, 0, 1, 0, 0, 0);
    run_out(2, 2);

    // Randomized mix checked against the queue model
    for (int it = 0; it < 80; it++) begin
      case ($urandom % 6)
        0: data_wr($urandom);
        1: data_rd();
        2: stat_rd(0);
        3: begin len = $urandom_range(0, 17); ctrl(len, 0, 0, 1, $urandom % 3, 0); end
        4: begin
          len = $urandom_range(0, 17);
          ctrl(len, 1, 0, 1, $urandom % 2, $urandom_range(1, (len > 0 ? len : 1) + 1));
        end
        default: begin
          if ($urandom % 3 == 0) stat_wr($urandom);
          else if ($urandom % 2 == 0) acc("ctrl_rd", 0, 8'h04, 0, 1, 0);
          else begin
            a = 8'($urandom);
            if (a == 8'h00 || a == 8'h04 || a == 8'h08) a = 8'h0C;
            acc("unmapped", 1'($urandom % 2), a, $urandom, 1, 0);
          end
        end
      endcase
    end

    // Asynchronous reset in the middle of an OUT burst
    while (tx_q.size() > 0) begin
      ctrl(tx_q.size() > DEPTH ? DEPTH : tx_q.size(), 0, 0, 1, 0, 0);
    end
    for (int i = 0; i < 5; i++) data_wr(32'hD0 + 32'(i));
    ctrl(5, 0, 0, 0, 0, 0);
    burst_ready = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    burst_ready = 0;
    chk("mid_valid", burst_valid, 1);
    rst_n = 0;
    #1;
    chk("ar_idle", idle, 1);
    chk("ar_bvalid", burst_valid, 0);
    chk("ar_blast", burst_last, 0);
    chk("ar_dbready", db_ready, 0);
    chk("ar_dblen", db_length, 0);
    chk("ar_rd_done", apb_rd_done, 0);
`ifdef APBTOBURST_IRQ_EN
    chk("ar_irq", irq, 0);
`endif
    tx_q.delete(); rx_q.delete(); seq_m = 0; irq_m = 0;
    @(posedge clk); #3;
    rst_n = 1;
    @(posedge clk); #1;
    acc("post_rst_status", 0, 8'h08, 0, 0, 32'h0);
    ctrl(2, 0, 0, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
